imm_ext_ctrl: RTL

IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

---
 rtl/imm_ext_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imm_ext_ctrl.sv
// Immediate-field extender with up to two 6-bit prefix words concatenated ahead
// of the final field, behind a one-entry output buffer with valid/ready handshakes.
module imm_ext_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  imm,
    input  logic [1:0]  mode,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out,
    output logic [1:0]  pfx_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_PREFIX = 2'b11;

    state_t       state_reg, state_next;
    // The prefix shift register is architecturally 12 bits, but bits above
    // the low 10 are shifted out before any consumer can observe them.
    logic [9:0]   acc_reg, acc_next;
    logic [15:0]  out_reg, out_next;
    logic         out_valid_reg, out_valid_next;
    logic         err_reg, err_next;

    logic         in_xfer;
    logic         out_xfer;
    logic         is_prefix;
    logic [15:0]  concat;
    logic [15:0]  cand_sext  [3];
    logic [15:0]  cand_zext  [3];
    logic [15:0]  cand_shift [3];
    logic [15:0]  sel_sext;
    logic [15:0]  sel_zext;
    logic [15:0]  sel_shift;
    logic [15:0]  ext_val;

    assign in_ready  = ~flush & (~out_valid_reg | out_ready);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid_reg & out_ready;
    assign is_prefix = (mode == MODE_PREFIX);
    assign concat    = {acc_reg, imm};

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign pfx_cnt   = state_reg;
    assign err       = err_reg;

    // One candidate set per prefix depth: depth gi sees the low 6*(gi+1) bits
    // of the concatenation, capped at the 16-bit operand width.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_depth
            localparam int N = (gi == 2) ? 16 : 6 * (gi + 1);
            logic [N-1:0] raw;
            logic [15:0]  sx;
            assign raw             = concat[N-1:0];
            assign sx              = 16'(signed'(raw));
            assign cand_sext[gi]   = sx;
            assign cand_zext[gi]   = 16'(raw);
            assign cand_shift[gi]  = {sx[14:0], 1'b0};
        end
    endgenerate

    always_comb begin
        sel_sext  = cand_sext[0];
        sel_zext  = cand_zext[0];
        sel_shift = cand_shift[0];
        case (state_reg)
            P1: begin
                sel_sext  = cand_sext[1];
                sel_zext  = cand_zext[1];
                sel_shift = cand_shift[1];
            end
            P2: begin
                sel_sext  = cand_sext[2];
                sel_zext  = cand_zext[2];
                sel_shift = cand_shift[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        ext_val = sel_shift;
        case (mode)
            MODE_SEXT: ext_val = sel_sext;
            MODE_ZEXT: ext_val = sel_zext;
            default:   ext_val = sel_shift;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        err_next       = err_reg;

        if (flush) begin
            state_next     = P0;
            acc_next       = '0;
            out_valid_next = 1'b0;
        end else if (in_xfer && is_prefix) begin
            acc_next = {acc_reg[3:0], imm};
            case (state_reg)
                P0:      state_next = P1;
                P1:      state_next = P2;
                default: begin
                    state_next = P2;
                    err_next   = 1'b1;
                end
            endcase
            if (out_xfer) begin
                out_valid_next = 1'b0;
            end
        end else if (in_xfer) begin
            out_next       = ext_val;
            out_valid_next = 1'b1;
            state_next     = P0;
            acc_next       = '0;
        end else if (out_xfer) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= P0;
            acc_reg       <= '0;
            out_reg       <= 16'h0000;
            out_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            err_reg       <= err_next;
        end
    end

endmodule
